// File: rtl/pol_to_rect.sv
// Pipelined rotation-mode CORDIC: polar (magnitude, binary angle) -> signed real/imag.
// Define POL_TO_RECT_SAT_EN to clamp out-of-range results and drive sat_o; otherwise results wrap.

module pol_to_rect_rot #(
    parameter int XW    = 15,
    parameter int SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 dir,
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o
);
    // dir=1 rotates counter-clockwise (residual angle still non-negative)
    always_ff @(posedge clk) begin
        if (dir) begin
            x_o <= x_i - (y_i >>> SHIFT);
            y_o <= y_i + (x_i >>> SHIFT);
        end else begin
            x_o <= x_i + (y_i >>> SHIFT);
            y_o <= y_i - (x_i >>> SHIFT);
        end
    end
endmodule

module pol_to_rect #(
    parameter int DATA_W = 8,
    parameter int ANG_W  = 16,
    parameter int ITER   = 12,
    parameter int GUARD  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              val_i,
    input  logic [DATA_W-1:0] abs_i,
    input  logic [ANG_W-1:0]  angle_i,
    output logic              val_o,
    output logic [DATA_W-1:0] real_o,
    output logic [DATA_W-1:0] imag_o,
    output logic              sat_o
);
    localparam int XW = DATA_W + GUARD + 3;
    localparam int ZW = ANG_W;
    localparam int KW = 16;
    localparam int PW = XW + KW;
    localparam int SH = 15 + GUARD;
    localparam logic signed [KW-1:0] KS   = 16'sd19898;
    localparam logic signed [PW-1:0] RND  = PW'(1) << (14 + GUARD);
    localparam logic [ZW-1:0]        HALF = ZW'(1) << (ANG_W - 3);

    // atan(2^-i) in a 2^16-per-turn table, rescaled to ANG_W at elaboration
    function automatic logic [ZW-1:0] atan_ang(input int i);
        int unsigned t;
        case (i)
            0: t = 8192;   1: t = 4836;  2: t = 2555;  3: t = 1297;
            4: t = 651;    5: t = 326;   6: t = 163;   7: t = 81;
            8: t = 41;     9: t = 20;   10: t = 10;   11: t = 5;
            12: t = 3;    13: t = 1;    14: t = 1;    default: t = 0;
        endcase
        return ZW'((64'(t) << ANG_W) >> 16);
    endfunction

    logic [ITER+2:0]          vld_pipe;
    logic [ITER:0][XW-1:0]    xs, ys;
    logic [ITER-1:0][ZW-1:0]  zs;
    logic signed [XW-1:0]     mag, xq, yq;
    logic signed [PW-1:0]     prod_re, prod_im;
    logic [DATA_W-1:0]        real_c, imag_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[ITER+1:0], val_i};
    end
    assign val_o = vld_pipe[ITER+2];

    assign mag = $signed({3'b000, abs_i, {GUARD{1'b0}}});

    always_comb begin
        xq = '0;
        yq = '0;
        case (angle_i[ANG_W-1 -: 2])
            2'b00:   xq = mag;
            2'b01:   yq = mag;
            2'b10:   xq = -mag;
            default: yq = -mag;
        endcase
    end

    // Quadrant fold fused with the i=0 micro-rotation: residual z is always >= 0 here
    always_ff @(posedge clk) begin
        xs[0] <= xq - yq;
        ys[0] <= yq + xq;
        zs[0] <= ZW'({2'b00, angle_i[ANG_W-3:0]}) - HALF;
    end

    for (genvar k = 1; k <= ITER; k++) begin : g_stage
        pol_to_rect_rot #(.XW(XW), .SHIFT(k)) u_rot (
            .clk (clk),
            .dir (~zs[k-1][ZW-1]),
            .x_i (xs[k-1]),
            .y_i (ys[k-1]),
            .x_o (xs[k]),
            .y_o (ys[k])
        );
        if (k < ITER) begin : g_z
            localparam logic [ZW-1:0] ATAN_K = atan_ang(k);
            always_ff @(posedge clk) begin
                if (!zs[k-1][ZW-1]) zs[k] <= zs[k-1] - ATAN_K;
                else                zs[k] <= zs[k-1] + ATAN_K;
            end
        end
    end

    always_ff @(posedge clk) begin
        prod_re <= $signed(xs[ITER]) * KS;
        prod_im <= $signed(ys[ITER]) * KS;
    end

`ifdef POL_TO_RECT_SAT_EN
    localparam logic signed [PW-1:0] MAXV = PW'(2**(DATA_W-1) - 1);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    logic signed [PW-1:0] re_q, im_q;
    logic                 sat_c;

    function automatic logic [DATA_W-1:0] clip(input logic signed [PW-1:0] v);
        if (v > MAXV)      return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v < MINV) return {1'b1, {(DATA_W-1){1'b0}}};
        else               return v[DATA_W-1:0];
    endfunction

    assign re_q   = (prod_re + RND) >>> SH;
    assign im_q   = (prod_im + RND) >>> SH;
    assign real_c = clip(re_q);
    assign imag_c = clip(im_q);
    assign sat_c  = (re_q > MAXV) || (re_q < MINV) || (im_q > MAXV) || (im_q < MINV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_o <= 1'b0;
        else        sat_o <= vld_pipe[ITER+1] & sat_c;
    end
`else
    assign real_c = DATA_W'((prod_re + RND) >>> SH);
    assign imag_c = DATA_W'((prod_im + RND) >>> SH);
    assign sat_o  = 1'b0;
`endif

    // Data outputs only move on valid samples so they hold through bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            real_o <= '0;
            imag_o <= '0;
        end else if (vld_pipe[ITER+1]) begin
            real_o <= real_c;
            imag_o <= imag_c;
        end
    end
endmodule

// File: tb/tb_pol_to_rect.sv
// Directed + random bench for pol_to_rect with a queue scoreboard and latency tracking.
module tb_pol_to_rect;
    logic        clk, rst_n, val_i, val_o, sat_o;
    logic [7:0]  abs_i, real_o, imag_o;
    logic [15:0] angle_i;

    typedef struct {
        int er;
        int ei;
        bit es;
        int issue;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0, n_bad = 0, cyc = 0;
    bit          have_last = 0;
    logic [7:0]  last_re, last_im;

    pol_to_rect dut (
        .clk(clk), .rst_n(rst_n), .val_i(val_i), .abs_i(abs_i), .angle_i(angle_i),
        .val_o(val_o), .real_o(real_o), .imag_o(imag_o), .sat_o(sat_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rnd(real v);
        return $rtoi($floor(v + 0.5));
    endfunction

    function automatic bit near(logic [7:0] a, int e);
        logic [7:0] ev, d;
        ev = e[7:0];
        d  = a - ev;
        return ($signed(d) >= -1) && ($signed(d) <= 1);
    endfunction

    task automatic send(int a, int ang);
        exp_t e;
        real  th;
        th = 2.0 * 3.14159265358979 * ang / 65536.0;
        e.er = rnd(a * $cos(th));
        e.ei = rnd(a * $sin(th));
`ifdef POL_TO_RECT_SAT_EN
        e.es = (e.er > 127) || (e.er < -128) || (e.ei > 127) || (e.ei < -128);
        if (e.er > 127) e.er = 127;
        if (e.er < -128) e.er = -128;
        if (e.ei > 127) e.ei = 127;
        if (e.ei < -128) e.ei = -128;
`else
        e.es = 1'b0;
`endif
        e.issue = cyc + 1;
        q.push_back(e);
        val_i = 1'b1; abs_i = 8'(a); angle_i = 16'(ang);
        @(posedge clk); #2;
        val_i = 1'b0;
    endtask

    task automatic idle(int n);
        val_i = 1'b0;
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 200) begin @(posedge clk); #2; t++; end
        n_vec++;
        assert (q.size() === 0) else begin
            n_bad++; $error("FAIL drain: %0d outputs still pending, want 0", q.size());
        end
    endtask

    // Output monitor: scoreboard pop on val_o, hold check on bubbles
    always @(negedge clk) begin
        if (rst_n) begin
            if (val_o) begin
                n_vec++;
                assert (q.size() != 0) else begin
                    n_bad++; $error("FAIL spurious_val: val_o=1 at cycle %0d with nothing expected", cyc);
                end
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    n_vec++;
                    assert (near(real_o, e.er) === 1'b1) else begin
                        n_bad++; $error("FAIL real: got %0d want %0d+-1", $signed(real_o), e.er);
                    end
                    n_vec++;
                    assert (near(imag_o, e.ei) === 1'b1) else begin
                        n_bad++; $error("FAIL imag: got %0d want %0d+-1", $signed(imag_o), e.ei);
                    end
                    n_vec++;
                    assert (sat_o === e.es) else begin
                        n_bad++; $error("FAIL sat: got %b want %b", sat_o, e.es);
                    end
                    n_vec++;
                    assert ((cyc - e.issue) === 14) else begin
                        n_bad++; $error("FAIL latency: got %0d want 14", cyc - e.issue);
                    end
                end
                last_re = real_o; last_im = imag_o; have_last = 1'b1;
            end else if (have_last) begin
                n_vec++;
                assert ({real_o, imag_o} === {last_re, last_im}) else begin
                    n_bad++; $error("FAIL hold: got %h/%h want %h/%h", real_o, imag_o, last_re, last_im);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; val_i = 0; abs_i = 0; angle_i = 0;
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        assert ({val_o, real_o, imag_o, sat_o} === 18'd0) else begin
            n_bad++; $error("FAIL reset_state: got %b/%h/%h/%b want all 0", val_o, real_o, imag_o, sat_o);
        end
        rst_n = 1;
        idle(2);

        // Quadrant corners, back to back
        send(100, 16'h0000); send(100, 16'h4000); send(100, 16'h8000); send(100, 16'hC000);
        send(127, 16'h2000); send(50, 16'h1555);
        drain();

        // Contiguous random polar stream
        for (int i = 0; i < 1024; i++) send($urandom_range(0, 127), $urandom_range(0, 65535));
        drain();

        // Bubble pattern: alternating valid, then a 5-cycle gap
        for (int i = 0; i < 8; i++) begin
            send($urandom_range(1, 127), $urandom_range(0, 65535));
            idle(1);
        end
        idle(5);
        send(80, 16'h6000); send(33, 16'hA123); send(120, 16'hF000);
        drain();

        // Out-of-range magnitude
        send(255, 16'h0000);
        drain();

        // Reset with samples in flight
        for (int i = 0; i < 6; i++) send(90, 16'h1000 * i);
        rst_n = 0;
        q.delete();
        have_last = 1'b0;
        #1;
        n_vec++;
        assert ({val_o, real_o, imag_o} === 17'd0) else begin
            n_bad++; $error("FAIL async_reset: got %b/%h/%h want all 0", val_o, real_o, imag_o);
        end
        @(posedge clk); #2;
        rst_n = 1;
        idle(20);
        send(64, 16'h3000);
        drain();
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pol_to_rect.md
Name: pol_to_rect

Overview:
- Inverse of the magnitude/angle calculator: converts a polar sample (8-bit magnitude, 16-bit binary angle) back to an 8-bit signed real/imag pair.
- Fully pipelined CORDIC in rotation mode; accepts one sample per clock.
- Sits after the magnitude/angle stage so processed polar data can be re-synthesised and checked round-trip against the original real/imag samples.

Parameters:
- DATA_W, 8, width of abs_i, real_o and imag_o.
- ANG_W, 16, width of angle_i; unsigned binary angle, 2^ANG_W maps to 2*pi.
- ITER, 12, number of CORDIC micro-rotation stages (range 8..15).
- GUARD, 4, extra fractional bits carried in the x/y datapath.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- val_i  in  1  input sample valid.
- abs_i  in  DATA_W  unsigned magnitude.
- angle_i  in  ANG_W  unsigned angle: 0x0000=0, 0x4000=pi/2, 0x8000=pi, 0xC000=3pi/2.
- val_o  out  1  output valid.
- real_o  out  DATA_W  signed two's complement, abs*cos(angle).
- imag_o  out  DATA_W  signed two's complement, abs*sin(angle).
- sat_o  out  1  result clipped (feature-dependent, see below).

Behaviour:
- Reset: val_o=0, real_o=0, imag_o=0, sat_o=0.
- Reset clears the whole valid pipeline asynchronously. In-flight samples are discarded.
- After rst_n deasserts, val_o stays 0 until a new val_i=1 sample has traversed the pipeline.
- No backpressure. Every val_i=1 cycle produces exactly one val_o=1 cycle.
- Latency is fixed at ITER+2 cycles (14 with defaults). Inputs sampled at edge N appear on outputs at edge N+ITER+2.
- Bubbles (val_i=0) propagate as val_o=0. On val_o=0, data outputs hold their last valid value.
- Stage 0, quadrant pre-rotation, driven by angle_i[ANG_W-1:ANG_W-2]. x0=abs<<GUARD, z0 = angle with the top two bits cleared, then:
  - 00: (x,y) = (x0, 0)
  - 01: (x,y) = (0, x0)
  - 10: (x,y) = (-x0, 0)
  - 11: (x,y) = (0, -x0)
  The residual z lies in [0, pi/2). It is re-centred to [-pi/4, pi/4) by subtracting 0x2000 and rotating the pair by +pi/4 via the standard first stage.
- Stages 1..ITER, standard rotation:
  - d = sign(z).
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan(2^-i).
  - atan constants are in ANG_W-bit binary-angle units, ROM-free as localparams.
  - Arithmetic shifts throughout.
- x/y internal width is DATA_W+GUARD+3 signed, so no overflow at any stage.
- Final stage, gain compensation:
  - Multiply by K = 19898 (0.60725 in Q0.15).
  - Round half up: result = (prod + 2^(14+GUARD)) >>> (15+GUARD).
- Accuracy: |real_o - round(abs*cos)| <= 1 and likewise for imag_o, for all abs_i <= 127 and all angles.
- A result outside [-2^(DATA_W-1), 2^(DATA_W-1)-1] is handled per the optional feature. This occurs only when abs_i > 127.
- A simultaneous val_i on the same edge as rst_n deassertion is ignored.

Optional Feature:
POL_TO_RECT_SAT_EN
- Defined:
  - Out-of-range results clamp to 127 / -128 (DATA_W=8).
  - sat_o=1 in the same cycle as the affected val_o when either real or imag clipped; otherwise sat_o=0.
- Undefined:
  - Results are truncated to the low DATA_W bits (two's-complement wrap).
  - sat_o is tied to 0.
  - No clamp logic is synthesised.

Test Plan:
- Reset, then abs_i=100 with each of angle 0x0000 / 0x4000 / 0x8000 / 0xC000, one per cycle -> (100,0), (0,100), (-100,0), (0,-100) within ±1. First val_o exactly 14 cycles after the first val_i.
- abs_i=127, angle_i=0x2000 -> real_o=90, imag_o=90 (±1). abs_i=50, angle_i=0x1555 (30 deg) -> (43,25) ±1.
- Feed 1024 contiguous vectors from the magnitude/angle stage reference results (abs, angle) -> real_o/imag_o match the original real/imag stimulus within ±1 and are in-order. val_o is high for exactly 1024 cycles.
- Alternate val_i 1/0 and insert a 5-cycle gap -> identical bubble pattern on val_o, delayed 14 cycles. Data outputs hold during bubbles.
- abs_i=255, angle_i=0 -> with POL_TO_RECT_SAT_EN: real_o=127, sat_o=1. Without: real_o=0xFF (wrap), sat_o=0.
- Assert rst_n=0 for 1 cycle while 6 samples are in flight -> val_o/real_o/imag_o go to 0 immediately. No val_o pulse occurs until 14 cycles after the next val_i.
